// File: rtl/sc_receiver.sv
// Slow-control serial frame receiver: synchronizes ck_sc/d_sc/rstn_sc, shifts bits LSB first, publishes whole frames.
// Optional frame comparator enabled by defining SC_RX_CHECK_EN (adds exp_frame, match, mismatch).
module sc_receiver #(
  parameter int FRAME_LEN   = 829,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ck_sc,
  input  logic                 d_sc,
  input  logic                 rstn_sc,
`ifdef SC_RX_CHECK_EN
  input  logic [FRAME_LEN-1:0] exp_frame,
  output logic                 match,
  output logic                 mismatch,
`endif
  output logic [FRAME_LEN-1:0] frame,
  output logic [9:0]           dac1,
  output logic [9:0]           dac2,
  output logic                 frame_valid,
  output logic                 busy,
  output logic [9:0]           bit_cnt,
  output logic                 overrun,
  output logic                 abort
);

  localparam logic [9:0] LAST = 10'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ck_sr, d_sr, rstn_sr;
  logic                   ck_prev;
  logic [FRAME_LEN-1:0]   shreg;
  logic                   sync_ck, sync_d, sync_rstn, ck_rise;

  // All three chains have the same depth so data and frame reset line up with the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_sr   <= '0;
      d_sr    <= '0;
      rstn_sr <= '0;
      ck_prev <= 1'b0;
    end else begin
      ck_sr[0]   <= ck_sc;
      d_sr[0]    <= d_sc;
      rstn_sr[0] <= rstn_sc;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ck_sr[i]   <= ck_sr[i-1];
        d_sr[i]    <= d_sr[i-1];
        rstn_sr[i] <= rstn_sr[i-1];
      end
      ck_prev <= sync_ck;
    end
  end

  assign sync_ck   = ck_sr[SYNC_STAGES-1];
  assign sync_d    = d_sr[SYNC_STAGES-1];
  assign sync_rstn = rstn_sr[SYNC_STAGES-1];
  assign ck_rise   = sync_ck & ~ck_prev;

  assign dac1 = frame[22:13];
  assign dac2 = frame[12:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      frame       <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      abort       <= 1'b0;
`ifdef SC_RX_CHECK_EN
      match       <= 1'b0;
      mismatch    <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      abort       <= 1'b0;
`ifdef SC_RX_CHECK_EN
      match       <= 1'b0;
      mismatch    <= 1'b0;
`endif
      if (!sync_rstn) begin
        state   <= IDLE;
        shreg   <= '0;
        bit_cnt <= '0;
        busy    <= 1'b0;
        overrun <= 1'b0;
        abort   <= (state == SHIFT);
      end else begin
        case (state)
          IDLE: begin
            if (ck_rise) begin
              shreg   <= {sync_d, shreg[FRAME_LEN-1:1]};
              bit_cnt <= 10'd1;
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            // Commit one cycle after the final capture so a coincident frame reset can still cancel it.
            if (bit_cnt == LAST) begin
              frame       <= shreg;
              frame_valid <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
`ifdef SC_RX_CHECK_EN
              match       <= (shreg == exp_frame);
              mismatch    <= (shreg != exp_frame);
`endif
            end else if (ck_rise) begin
              shreg   <= {sync_d, shreg[FRAME_LEN-1:1]};
              bit_cnt <= bit_cnt + 10'd1;
            end
          end
          DONE: begin
            if (ck_rise) overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc_receiver.sv
// Randomized frame bench for sc_receiver with a queue scoreboard checked on every frame_valid.
module tb_sc_receiver;
  localparam int FL = 829;

  logic          clk = 1'b0;
  logic          rst, ck_sc, d_sc, rstn_sc;
  logic [FL-1:0] frame;
  logic [9:0]    dac1, dac2, bit_cnt;
  logic          frame_valid, busy, overrun, abort;
  logic [FL-1:0] exp_frame;
`ifdef SC_RX_CHECK_EN
  logic          match, mismatch;
`endif

  sc_receiver #(.FRAME_LEN(FL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ck_sc(ck_sc), .d_sc(d_sc), .rstn_sc(rstn_sc),
`ifdef SC_RX_CHECK_EN
    .exp_frame(exp_frame), .match(match), .mismatch(mismatch),
`endif
    .frame(frame), .dac1(dac1), .dac2(dac2), .frame_valid(frame_valid),
    .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FL-1:0] frm;
    logic          m;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, passed = 0;
  int   fv_count = 0, ab_count = 0;
  int   edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic chk_frame(input string name, input logic [FL-1:0] act, input logic [FL-1:0] req);
    int nbad = 0, first = -1;
    checks++;
    for (int i = 0; i < FL; i++)
      if (act[i] !== req[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    if (nbad == 0) passed++;
    else $display("FAIL %s: %0d bits differ, first at bit %0d (got %b, expected %b)",
                  name, nbad, first, act[first], req[first]);
  endtask

  // Scoreboard: every frame_valid must match the oldest frame the stimulus announced.
  always @(negedge clk) begin
    if (!rst && abort) ab_count++;
    if (!rst && frame_valid) begin
      fv_count++;
      if (exp_q.size() == 0) chk("unexpected_frame_valid", 32'(frame_valid), 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_frame("frame", frame, e.frm);
        chk("dac1", 32'(dac1), 32'(e.frm[22:13]));
        chk("dac2", 32'(dac2), 32'(e.frm[12:3]));
`ifdef SC_RX_CHECK_EN
        chk("match", 32'(match), 32'(e.m));
        chk("mismatch", 32'(mismatch), 32'(!e.m));
`endif
      end
    end
  end

  function automatic logic [FL-1:0] rand_frame();
    logic [FL-1:0] r;
    for (int i = 0; i < FL; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt();
    return (edges > FL) ? FL : edges;
  endfunction

  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    d_sc  = b;
    ck_sc = 1'b0;
    repeat (half) @(negedge clk);
    ck_sc = 1'b1;
    edges++;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [FL-1:0] v, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) send_bit(v[i], half);
  endtask

  task automatic push_exp(input logic [FL-1:0] v);
    exp_t e;
    e.frm = v;
    e.m   = (exp_frame == v);
    exp_q.push_back(e);
  endtask

  task automatic rstn_pulse();
    @(negedge clk);
    rstn_sc = 1'b0;
    edges   = 0;
    repeat (5) @(negedge clk);
    rstn_sc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  logic [FL-1:0] v0, v1, v2, v3, v4, v5, v6, v7;
  int fv0, ab0;

  initial begin
    rst = 1'b1; ck_sc = 1'b0; d_sc = 1'b0; rstn_sc = 1'b1; exp_frame = '0;
    repeat (3) @(negedge clk);
    chk_frame("reset_frame", frame, '0);
    chk("reset_bit_cnt", 32'(bit_cnt), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_outputs", {26'd0, frame_valid, overrun, abort, 1'b0, |dac1, |dac2}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame
    v0 = rand_frame();
    send_frame(v0, 400, 8);
    repeat (2) @(negedge clk);
    chk("midframe_bit_cnt", 32'(bit_cnt), exp_cnt());
    chk("midframe_busy", 32'(busy), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_frame("rst_mid_frame", frame, '0);
    chk("rst_mid_bit_cnt", 32'(bit_cnt), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    ck_sc = 1'b0;
    rst   = 1'b0;
    edges = 0;
    repeat (5) @(negedge clk);

    // Full frame with known DAC fields
    v1 = rand_frame();
    v1[22:13] = 10'h15A;
    v1[12:3]  = 10'h2A5;
    exp_frame = v1;
    fv0 = fv_count;
    push_exp(v1);
    send_frame(v1, FL, 8);
    repeat (6) @(negedge clk);
    chk("full_fv_pulses", 32'(fv_count - fv0), 1);
    chk("full_dac2", 32'(dac2), 32'h2A5);
    chk("full_dac1", 32'(dac1), 32'h15A);
    chk("full_busy", 32'(busy), 0);

    // Abort after bit 300, then a clean frame
    ab0 = ab_count;
    rstn_pulse();
    chk("no_abort_in_done", 32'(ab_count - ab0), 0);
    v2 = rand_frame();
    fv0 = fv_count;
    send_frame(v2, 300, 6);
    repeat (2) @(negedge clk);
    chk("pre_abort_bit_cnt", 32'(bit_cnt), exp_cnt());
    rstn_sc = 1'b0;
    edges   = 0;
    repeat (6) @(negedge clk);
    chk("abort_pulses", 32'(ab_count - ab0), 1);
    chk("abort_bit_cnt", 32'(bit_cnt), 0);
    chk("abort_busy", 32'(busy), 0);
    chk_frame("abort_frame_held", frame, v1);
    chk("abort_no_fv", 32'(fv_count - fv0), 0);
    rstn_sc = 1'b1;
    repeat (5) @(negedge clk);
    v3 = rand_frame();
    exp_frame = v3;
    push_exp(v3);
    send_frame(v3, FL, 6);
    repeat (6) @(negedge clk);
    chk("post_abort_fv", 32'(fv_count - fv0), 1);

    // Overrun: one edge beyond the frame length
    rstn_pulse();
    v4 = rand_frame();
    exp_frame = v4;
    fv0 = fv_count;
    push_exp(v4);
    send_frame(v4, FL, 6);
    repeat (6) @(negedge clk);
    chk("ovr_fv", 32'(fv_count - fv0), 1);
    chk("ovr_before", 32'(overrun), 32'(edges > FL));
    chk("ovr_bit_cnt", 32'(bit_cnt), exp_cnt());
    send_bit(1'b1, 6);
    repeat (4) @(negedge clk);
    chk("ovr_after", 32'(overrun), 32'(edges > FL));
    chk("ovr_bit_cnt_sat", 32'(bit_cnt), exp_cnt());
    chk_frame("ovr_frame_held", frame, v4);
    chk("ovr_fv_once", 32'(fv_count - fv0), 1);
    rstn_sc = 1'b0;
    edges   = 0;
    repeat (5) @(negedge clk);
    chk("ovr_cleared", 32'(overrun), 0);
    rstn_sc = 1'b1;
    repeat (5) @(negedge clk);

    // Frame reset arriving with the final bit
    v5 = rand_frame();
    fv0 = fv_count;
    ab0 = ab_count;
    send_frame(v5, FL - 1, 6);
    @(negedge clk);
    d_sc  = v5[FL-1];
    ck_sc = 1'b0;
    repeat (6) @(negedge clk);
    ck_sc   = 1'b1;
    rstn_sc = 1'b0;
    edges   = 0;
    repeat (8) @(negedge clk);
    chk("simul_abort", 32'(ab_count - ab0), 1);
    chk("simul_no_fv", 32'(fv_count - fv0), 0);
    chk("simul_bit_cnt", 32'(bit_cnt), 0);
    chk_frame("simul_frame_held", frame, v4);
    rstn_sc = 1'b1;
    repeat (5) @(negedge clk);

`ifdef SC_RX_CHECK_EN
    v6 = rand_frame();
    exp_frame = v6;
    push_exp(v6);
    send_frame(v6, FL, 6);
    repeat (6) @(negedge clk);
    rstn_pulse();
    v7 = rand_frame();
    exp_frame = v7;
    exp_frame[500] = ~exp_frame[500];
    push_exp(v7);
    send_frame(v7, FL, 6);
    repeat (6) @(negedge clk);
`else
    v6 = '0;
    v7 = '0;
`endif

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
